// File: rtl/uart_parity_engine.sv
// Bit-serial parity generator/checker shared by UART TX and RX.
// Accumulates parity over the configured data bits, then supplies or checks the parity slot.
module uart_parity_engine #(
  parameter int unsigned MAX_DSIZE = 9,
  parameter int unsigned CW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] cfg_width,
  input  logic [2:0]    cfg_mode,
  input  logic          bit_vld,
  input  logic          bit_in,
  input  logic          par_vld,
  input  logic          par_in,
  input  logic          err_clr,
  output logic          busy,
  output logic [CW-1:0] bit_cnt,
  output logic          par_rdy,
  output logic          par_bit,
  output logic          frame_done,
  output logic          par_err,
  output logic          par_err_sticky,
  output logic          seq_err_sticky
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic [2:0] MODE_NONE  = 3'd0;
  localparam logic [2:0] MODE_ODD   = 3'd1;
  localparam logic [2:0] MODE_EVEN  = 3'd2;
  localparam logic [2:0] MODE_MARK  = 3'd3;
  localparam logic [2:0] MODE_SPACE = 3'd4;

  localparam logic [CW-1:0] W_DEFAULT = CW'(8);
  localparam logic [CW-1:0] W_MIN     = CW'(5);
  localparam logic [CW-1:0] W_MAX     = CW'(MAX_DSIZE);

  state_t        state;
  logic [CW-1:0] width_q;
  logic [2:0]    mode_q;
  logic          acc;

  logic [CW-1:0] width_cfg;
  logic [2:0]    mode_cfg;
  logic [CW-1:0] cnt_nxt;
  logic          acc_nxt;
  logic          last_bit;
  logic          par_calc;
  logic          seq_evt;
  logic          perr_evt;

  // Config normalisation, next accumulator values and error-event decode
  always_comb begin
    width_cfg = W_DEFAULT;
    mode_cfg  = MODE_NONE;
    cnt_nxt   = bit_cnt + CW'(1);
    acc_nxt   = acc ^ bit_in;
    last_bit  = 1'b0;
    par_calc  = 1'b0;
    seq_evt   = 1'b0;
    perr_evt  = 1'b0;

    if ((cfg_width >= W_MIN) && (cfg_width <= W_MAX)) width_cfg = cfg_width;
    if (cfg_mode <= MODE_SPACE) mode_cfg = cfg_mode;
    last_bit = (cnt_nxt == width_q);

    case (mode_q)
      MODE_ODD:   par_calc = ~acc_nxt;
      MODE_EVEN:  par_calc = acc_nxt;
      MODE_MARK:  par_calc = 1'b1;
      MODE_SPACE: par_calc = 1'b0;
      default:    par_calc = 1'b0;
    endcase

    // start from IDLE is legal; any strobe riding along with it is simply dropped
    case (state)
      IDLE:    seq_evt = !start && (bit_vld || par_vld);
      DATA:    seq_evt = start || par_vld;
      PARITY:  seq_evt = start || bit_vld;
      default: seq_evt = 1'b0;
    endcase

    perr_evt = (state == PARITY) && !start && par_vld && (par_in != par_bit);
  end

  // Frame FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      width_q        <= W_DEFAULT;
      mode_q         <= MODE_NONE;
      acc            <= 1'b0;
      busy           <= 1'b0;
      bit_cnt        <= '0;
      par_rdy        <= 1'b0;
      par_bit        <= 1'b0;
      frame_done     <= 1'b0;
      par_err        <= 1'b0;
      par_err_sticky <= 1'b0;
      seq_err_sticky <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      par_err    <= 1'b0;

      if (seq_evt)      seq_err_sticky <= 1'b1;
      else if (err_clr) seq_err_sticky <= 1'b0;

      if (perr_evt)     par_err_sticky <= 1'b1;
      else if (err_clr) par_err_sticky <= 1'b0;

      if (start) begin
        state   <= DATA;
        busy    <= 1'b1;
        par_rdy <= 1'b0;
        acc     <= 1'b0;
        bit_cnt <= '0;
        width_q <= width_cfg;
        mode_q  <= mode_cfg;
      end else begin
        case (state)
          DATA: begin
            if (bit_vld) begin
              acc     <= acc_nxt;
              bit_cnt <= cnt_nxt;
              if (last_bit) begin
                if (mode_q != MODE_NONE) begin
                  state   <= PARITY;
                  par_rdy <= 1'b1;
                  par_bit <= par_calc;
                end else begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                end
              end
            end
          end
          PARITY: begin
            if (par_vld) begin
              state      <= IDLE;
              busy       <= 1'b0;
              par_rdy    <= 1'b0;
              frame_done <= 1'b1;
              par_err    <= perr_evt;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
